// File: rtl/dptr_multiciclo.sv
// ---------------------------------------------------------------------------
// dptr_multiciclo: multi-cycle datapath, shared ALU, FETCH/DECODE/EXEC/MEM/WB
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dptr_multiciclo #(
  parameter int                DATA_W   = 32,
  parameter int                NREGS    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [DATA_W-1:0] instr_addr,
  input  logic [31:0]       instr_rdata,
  input  logic              instr_valid,
  output logic              data_req,
  output logic              data_we,
  output logic [DATA_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_valid,
  output logic              zf,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam int RA_W = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_nxt;
  logic   retire;

  logic [DATA_W-1:0] pc, a, b, imm, alu_out, mdr;
  logic [31:0]       ir;
  logic [DATA_W-1:0] rf [NREGS];

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_halt, r_legal, legal;
  assign is_rtype = (op == OP_RTYPE);
  assign is_addi  = (op == OP_ADDI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_halt  = (op == OP_HALT);
  assign r_legal  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT) ||
                    ((funct == FN_NOP) && (rd == 5'd0));
  assign legal    = (is_rtype && r_legal) || is_addi || is_lw || is_sw || is_beq;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[10:6], rs, rt, rd};

  logic [DATA_W-1:0] rs_val, rt_val, imm_ext, op2, alu_res, pc_plus4, branch_tgt, wb_val;
  logic [RA_W-1:0]   wb_idx;

  assign rs_val   = (rs[RA_W-1:0] == '0) ? '0 : rf[rs[RA_W-1:0]];
  assign rt_val   = (rt[RA_W-1:0] == '0) ? '0 : rf[rt[RA_W-1:0]];
  assign imm_ext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign pc_plus4 = pc + DATA_W'(4);
  assign branch_tgt = pc_plus4 + (imm << 2);
  assign op2      = (is_rtype || is_beq) ? b : imm;
  assign wb_idx   = is_rtype ? rd[RA_W-1:0] : rt[RA_W-1:0];
  assign wb_val   = is_lw ? mdr : alu_out;

  // Address arithmetic shares the adder; beq compares by subtraction.
  always_comb begin
    alu_res = a + op2;
    if (is_beq) begin
      alu_res = a - op2;
    end else if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a - op2;
        FN_AND:  alu_res = a & op2;
        FN_OR:   alu_res = a | op2;
        FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(op2))};
        default: alu_res = a + op2;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_halt) begin
          state_nxt = S_HALT;
        end else if (!legal) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (data_valid) begin
          if (is_lw) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      zf      <= 1'b0;
      retired <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      case (state)
        S_FETCH: if (instr_valid) ir <= instr_rdata;
        S_DECODE: begin
          a   <= rs_val;
          b   <= rt_val;
          imm <= imm_ext;
          if (!legal && !is_halt) pc <= pc_plus4;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          zf      <= (alu_res == '0);
          if (is_beq) pc <= (alu_res == '0) ? branch_tgt : pc_plus4;
        end
        S_MEM: begin
          if (data_valid) begin
            if (is_lw) mdr <= data_rdata;
            else       pc  <= pc_plus4;
          end
        end
        S_WB: begin
          if (wb_idx != '0) rf[wb_idx] <= wb_val;
          pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Requests decode straight from state so an async reset drops them at once.
  assign instr_req  = (state == S_FETCH);
  assign instr_addr = pc;
  assign data_req   = (state == S_MEM);
  assign data_we    = (state == S_MEM) && is_sw;
  assign data_addr  = alu_out;
  assign data_wdata = b;
  assign halted     = (state == S_HALT);
  assign illegal    = (state == S_DECODE) && !legal && !is_halt;

endmodule

`default_nettype wire

// File: tb/tb_dptr_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_dptr_multiciclo: directed programs with fetch/data scoreboards
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dptr_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        zf;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  dptr_multiciclo dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .instr_valid(instr_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .zf(zf), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ret; int zf; } fexp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int hold; } dexp_t;

  fexp_t       fq[$];
  dexp_t       dq[$];
  logic [31:0] prog_q[$];
  int          dly_q[$];
  logic [31:0] dmem [16];
  int          checks = 0;
  int          errors = 0;
  int          ill_cnt = 0;
  logic        stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [31:0] addr, input logic [31:0] instr, input int ret, input int z);
    prog_q.push_back(instr);
    fq.push_back('{addr: addr, ret: ret, zf: z});
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int dly);
    dq.push_back('{we: we, addr: addr, wdata: wd, hold: dly + 1});
    dly_q.push_back(dly);
  endtask

  // Instruction memory: zero wait states, valid tied high.
  initial begin
    instr_valid = 1'b1;
    instr_rdata = '0;
    forever begin
      @(negedge clk);
      if (instr_req) instr_rdata = (prog_q.size() > 0) ? prog_q.pop_front() : 32'hFC00_0000;
    end
  end

  // Data memory: valid after the programmed number of wait cycles.
  initial begin
    int dcnt;
    dcnt = 0;
    data_valid = 1'b0;
    data_rdata = '0;
    forever begin
      @(negedge clk);
      if (data_req) begin
        dcnt++;
        if (dly_q.size() > 0 && dcnt == dly_q[0] + 1) begin
          data_valid = 1'b1;
          if (data_we) dmem[data_addr[5:2]] = data_wdata;
          else         data_rdata = dmem[data_addr[5:2]];
          void'(dly_q.pop_front());
        end else begin
          data_valid = 1'b0;
        end
      end else begin
        dcnt = 0;
        data_valid = stray;
      end
    end
  end

  // Monitor: pops expectations on every handshake.
  initial begin
    int    dhold;
    fexp_t fe;
    dexp_t de;
    dhold = 0;
    forever begin
      @(negedge clk);
      #3;
      if (illegal) ill_cnt++;
      if (instr_req && instr_valid) begin
        if (fq.size() == 0) begin
          check("fetch_unexpected", instr_addr, 32'hFFFF_FFFF);
        end else begin
          fe = fq.pop_front();
          check("fetch_addr", instr_addr, fe.addr);
          check("fetch_retired", {16'd0, retired}, fe.ret);
          if (fe.zf >= 0) check("fetch_zf", {31'd0, zf}, fe.zf);
        end
      end
      if (data_req) begin
        dhold++;
        if (data_valid) begin
          if (dq.size() == 0) begin
            check("data_unexpected", data_addr, 32'hFFFF_FFFF);
          end else begin
            de = dq.pop_front();
            check("data_we", {31'd0, data_we}, {31'd0, de.we});
            check("data_addr", data_addr, de.addr);
            if (de.we) check("data_wdata", data_wdata, de.wdata);
            check("data_req_hold", dhold, de.hold);
          end
          dhold = 0;
        end
      end else begin
        dhold = 0;
      end
    end
  end

  task automatic wait_halt(input string name);
    for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
    check(name, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    rst_n = 1'b0;

    push_f(32'h00, 32'h2001_0005,  0, 0);  // addi R1,R0,5
    push_f(32'h04, 32'hAC01_0000,  1, 0);  // sw R1,0(R0)
    push_d(1'b1, 32'd0, 32'd5, 0);
    push_f(32'h08, 32'h2001_FFFF,  2, 1);  // addi R1,R0,-1
    push_f(32'h0C, 32'h2002_0001,  3, 0);  // addi R2,R0,1
    push_f(32'h10, 32'h0022_1820,  4, 0);  // add R3,R1,R2
    push_f(32'h14, 32'h0001_2022,  5, 1);  // sub R4,R0,R1
    push_f(32'h18, 32'h0022_282A,  6, 0);  // slt R5,R1,R2
    push_f(32'h1C, 32'hAC03_0004,  7, 0);  // sw R3,4(R0)
    push_d(1'b1, 32'd4, 32'd0, 0);
    push_f(32'h20, 32'hAC04_000C,  8, 0);  // sw R4,12(R0)
    push_d(1'b1, 32'd12, 32'd1, 0);
    push_f(32'h24, 32'hAC05_0010,  9, 0);  // sw R5,16(R0)
    push_d(1'b1, 32'd16, 32'd1, 0);
    push_f(32'h28, 32'hAC01_0008, 10, 0);  // sw R1,8(R0), 3 wait cycles
    push_d(1'b1, 32'd8, 32'hFFFF_FFFF, 3);
    push_f(32'h2C, 32'h8C06_0008, 11, 0);  // lw R6,8(R0), 3 wait cycles
    push_d(1'b0, 32'd8, 32'd0, 3);
    push_f(32'h30, 32'hAC06_0014, 12, 0);  // sw R6,20(R0)
    push_d(1'b1, 32'd20, 32'hFFFF_FFFF, 0);
    push_f(32'h34, 32'h1000_FFFF, 13, 0);  // beq R0,R0,-1
    push_f(32'h34, 32'h1020_0002, 14, 1);  // beq R1,R0,+2 (not taken)
    push_f(32'h38, 32'h2000_0007, 15, 0);  // addi R0,R0,7
    push_f(32'h3C, 32'hAC00_0018, 16, 0);  // sw R0,24(R0)
    push_d(1'b1, 32'd24, 32'd0, 0);
    push_f(32'h40, 32'h5400_0000, 17, 0);  // illegal opcode
    push_f(32'h44, 32'h0000_0000, 18, 0);  // nop
    push_f(32'h48, 32'hFC00_0000, 19, -1); // halt

    repeat (3) @(negedge clk);
    check("rst_instr_req", {31'd0, instr_req}, 32'd0);
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_instr_addr", instr_addr, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_zf", {31'd0, zf}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("retire_early", {16'd0, retired}, 32'd0);
    @(posedge clk);
    #1 check("retire_first", {16'd0, retired}, 32'd1);

    wait_halt("halt_reached");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (instr_req) seen++;
    end
    check("halt_no_fetch", seen, 32'd0);
    check("illegal_pulses", ill_cnt, 32'd1);
    check("fetch_q_drained", fq.size(), 32'd0);
    check("data_q_drained", dq.size(), 32'd0);

    // Reset while a load is waiting on data memory.
    rst_n = 1'b0;
    @(negedge clk);
    push_f(32'h00, 32'h2001_0005, 0, 0);   // addi R1,R0,5
    push_f(32'h04, 32'h8C06_0008, 1, 0);   // lw R6,8(R0), never answered
    dly_q.push_back(100);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && !data_req; i++) @(negedge clk);
    check("lw_reached_mem", {31'd0, data_req}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    stray = 1'b1;
    #1;
    check("rst_drops_data_req", {31'd0, data_req}, 32'd0);
    check("rst_pc", instr_addr, 32'd0);
    check("rst_retired_mid", {16'd0, retired}, 32'd0);
    dly_q.delete();
    push_f(32'h00, 32'hAC01_0000, 0, 0);   // sw R1,0(R0): R1 cleared by reset
    push_d(1'b1, 32'd0, 32'd0, 0);
    push_f(32'h04, 32'hFC00_0000, 1, 1);   // halt
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    wait_halt("halt_after_reset");
    check("fetch_q_drained_2", fq.size(), 32'd0);
    check("data_q_drained_2", dq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
